// File: rtl/p_heap_if.sv
// p_heap_if: request/response bundle for the p_heap priority queue.
//   enq, deq, inp_data       : operation request (master -> slave)
//   out_data                 : current minimum, 0 when empty
//   full, empty, ready       : status; ready=1 means an operation may be issued
//   elem_cnt                 : number of stored entries
interface p_heap_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
);
  logic                  enq;
  logic                  deq;
  logic [DATA_WIDTH-1:0] inp_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  full;
  logic                  empty;
  logic                  ready;
  logic [CNT_WIDTH-1:0]  elem_cnt;

  modport master (
    output enq, deq, inp_data,
    input  out_data, full, empty, ready, elem_cnt
  );

  modport slave (
    input  enq, deq, inp_data,
    output out_data, full, empty, ready, elem_cnt
  );
endinterface

// File: rtl/p_heap.sv
// p_heap: pipelined binary min-heap priority queue (2**LEVELS-1 entries).
// Every accepted operation walks from the root towards the leaves one level per clock, so the
// root is settled one cycle after acceptance and a new operation may then be issued.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : p_heap_if slave (enq/deq/inp_data in; out_data/full/empty/ready/elem_cnt out)
module p_heap #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEVELS     = 5,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input logic     clk,
  input logic     rst_n,
  p_heap_if.slave bus
);
  localparam int unsigned Nodes = (1 << LEVELS) - 1;
  localparam int unsigned NodeW = $clog2(Nodes);
  localparam int unsigned FreeW = LEVELS;
  localparam int unsigned Leaf  = LEVELS - 1;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef enum logic [1:0] {OpEnq, OpDeq, OpRep} op_e;

  // Node storage, flat breadth-first numbering: children of n are 2n+1 and 2n+2.
  data_t            val_q [Nodes];
  data_t            val_d [Nodes];
  logic [Nodes-1:0] vld_q, vld_d;
  logic [FreeW-1:0] fl_q [Nodes];
  logic [FreeW-1:0] fl_d [Nodes];
  logic [FreeW-1:0] fr_q [Nodes];
  logic [FreeW-1:0] fr_d [Nodes];

  // One in-flight operation per level; tok_val carries the element moving down.
  logic [LEVELS-1:0] tok_vld_q, tok_vld_d;
  op_e               tok_op_q   [LEVELS];
  op_e               tok_op_d   [LEVELS];
  logic [NodeW-1:0]  tok_node_q [LEVELS];
  logic [NodeW-1:0]  tok_node_d [LEVELS];
  data_t             tok_val_q  [LEVELS];
  data_t             tok_val_d  [LEVELS];

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ready, full, empty;

  // Empty slots below each side of a node at reset: a full subtree of the level below.
  function automatic logic [FreeW-1:0] reset_free(int unsigned n);
    int unsigned lvl;
    lvl = 0;
    for (int unsigned k = 1; k < LEVELS; k++) begin
      if (n + 1 >= (1 << k)) lvl = k;
    end
    return FreeW'((1 << (LEVELS - 1 - lvl)) - 1);
  endfunction

  assign ready        = ~tok_vld_q[0];
  assign full         = (cnt_q == CNT_WIDTH'(Nodes));
  assign empty        = (cnt_q == '0);
  assign bus.ready    = ready;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.elem_cnt = cnt_q;
  assign bus.out_data = vld_q[0] ? val_q[0] : '0;

  always_comb begin
    logic [NodeW-1:0] n, l, r, m;
    data_t            c, carry;
    logic             pick_r;

    val_d      = val_q;
    vld_d      = vld_q;
    fl_d       = fl_q;
    fr_d       = fr_q;
    tok_vld_d  = '0;
    tok_op_d   = tok_op_q;
    tok_node_d = tok_node_q;
    tok_val_d  = tok_val_q;
    cnt_d      = cnt_q;
    n = '0; l = '0; r = '0; m = '0; c = '0; carry = '0; pick_r = 1'b0;

    // Inner levels: each stage writes only its own node and reads the level below, which the
    // previous operation (two levels ahead) has already finished with.
    for (int k = 0; k < int'(Leaf); k++) begin
      if (tok_vld_q[k]) begin
        n      = tok_node_q[k];
        c      = tok_val_q[k];
        l      = NodeW'({n, 1'b1});
        r      = l + NodeW'(1);
        // Smaller valid child; ties go left.
        pick_r = !vld_q[l] || (vld_q[r] && (val_q[r] < val_q[l]));
        m      = pick_r ? r : l;
        case (tok_op_q[k])
          OpEnq: begin
            if (!vld_q[n]) begin
              val_d[n] = c;
              vld_d[n] = 1'b1;
            end else begin
              carry = c;
              if (c < val_q[n]) begin
                val_d[n] = c;
                carry    = val_q[n];
              end
              tok_vld_d[k+1] = 1'b1;
              tok_op_d[k+1]  = OpEnq;
              tok_val_d[k+1] = carry;
              if (fl_q[n] != '0) begin
                fl_d[n]         = fl_q[n] - FreeW'(1);
                tok_node_d[k+1] = l;
              end else begin
                fr_d[n]         = fr_q[n] - FreeW'(1);
                tok_node_d[k+1] = r;
              end
            end
          end
          OpDeq: begin
            if (!vld_q[l] && !vld_q[r]) begin
              vld_d[n] = 1'b0;
            end else begin
              // The slot finally freed lies in the subtree the hole moves into.
              val_d[n] = val_q[m];
              if (pick_r) fr_d[n] = fr_q[n] + FreeW'(1);
              else        fl_d[n] = fl_q[n] + FreeW'(1);
              tok_vld_d[k+1]  = 1'b1;
              tok_op_d[k+1]   = OpDeq;
              tok_node_d[k+1] = m;
            end
          end
          OpRep: begin
            if ((vld_q[l] || vld_q[r]) && (val_q[m] < c)) begin
              val_d[n]        = val_q[m];
              tok_vld_d[k+1]  = 1'b1;
              tok_op_d[k+1]   = OpRep;
              tok_node_d[k+1] = m;
              tok_val_d[k+1]  = c;
            end else begin
              val_d[n] = c;
            end
          end
          default: ;
        endcase
      end
    end

    // Leaf level: no children, the operation always ends here.
    if (tok_vld_q[Leaf]) begin
      n = tok_node_q[Leaf];
      c = tok_val_q[Leaf];
      case (tok_op_q[Leaf])
        OpEnq: begin
          val_d[n] = c;
          vld_d[n] = 1'b1;
        end
        OpDeq:   vld_d[n] = 1'b0;
        OpRep:   val_d[n] = c;
        default: ;
      endcase
    end

    // Issue. enq+deq on an empty heap degrades to a plain enqueue.
    if (ready) begin
      tok_node_d[0] = '0;
      tok_val_d[0]  = bus.inp_data;
      if (bus.enq && bus.deq && !empty) begin
        tok_vld_d[0] = 1'b1;
        tok_op_d[0]  = OpRep;
      end else if (bus.enq && !full) begin
        tok_vld_d[0] = 1'b1;
        tok_op_d[0]  = OpEnq;
        cnt_d        = cnt_q + CNT_WIDTH'(1);
      end else if (bus.deq && !empty) begin
        tok_vld_d[0] = 1'b1;
        tok_op_d[0]  = OpDeq;
        cnt_d        = cnt_q - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Nodes; i++) begin
        val_q[i] <= '0;
        fl_q[i]  <= reset_free(i);
        fr_q[i]  <= reset_free(i);
      end
      for (int unsigned k = 0; k < LEVELS; k++) begin
        tok_op_q[k]   <= OpEnq;
        tok_node_q[k] <= '0;
        tok_val_q[k]  <= '0;
      end
      vld_q     <= '0;
      tok_vld_q <= '0;
      cnt_q     <= '0;
    end else begin
      val_q      <= val_d;
      vld_q      <= vld_d;
      fl_q       <= fl_d;
      fr_q       <= fr_d;
      tok_vld_q  <= tok_vld_d;
      tok_op_q   <= tok_op_d;
      tok_node_q <= tok_node_d;
      tok_val_q  <= tok_val_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_p_heap.sv
// tb_p_heap: self-checking bench for p_heap. Directed table of operations with hand-computed
// results, hand-written full/reset sequences, and a randomized run against a multiset model.
module tb_p_heap;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  p_heap_if bus ();

  p_heap dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] model[$];

  typedef struct {
    bit          e;
    bit          d;
    logic [31:0] x;
    logic [31:0] pre;
    logic [31:0] post;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_min();
    logic [31:0] m;
    if (model.size() == 0) return 32'd0;
    m = model[0];
    foreach (model[i]) if (model[i] < m) m = model[i];
    return m;
  endfunction

  function automatic void model_pop_min();
    int idx;
    idx = 0;
    foreach (model[i]) if (model[i] < model[idx]) idx = i;
    model.delete(idx);
  endfunction

  // Called at a falling edge. Issues one request, optionally throws a stray request into the
  // not-ready cycle that follows, and checks the settled state two cycles later.
  task automatic do_op(input bit e, input bit d, input logic [31:0] x, input bit junk,
                       output logic [31:0] pre_out);
    bit acc;
    for (int i = 0; i < 8 && bus.ready !== 1'b1; i++) @(negedge clk);
    chk("ready_wait", {31'd0, bus.ready}, 32'd1);
    pre_out = bus.out_data;
    chk("pre_out", bus.out_data, model_min());
    bus.enq      = e;
    bus.deq      = d;
    bus.inp_data = x;
    @(posedge clk);
    #1;
    acc = 1'b1;
    if (e && d && model.size() > 0) begin
      model_pop_min();
      model.push_back(x);
    end else if (e && model.size() < 31) begin
      model.push_back(x);
    end else if (d && model.size() > 0) begin
      model_pop_min();
    end else begin
      acc = 1'b0;
    end
    bus.enq = 1'b0;
    bus.deq = 1'b0;
    if (junk && acc) begin
      bus.enq      = 1'($urandom_range(0, 1));
      bus.deq      = 1'($urandom_range(0, 1));
      bus.inp_data = $urandom;
    end
    @(negedge clk);
    chk("ready_drop", {31'd0, bus.ready}, {31'd0, !acc});
    @(posedge clk);
    #1;
    bus.enq = 1'b0;
    bus.deq = 1'b0;
    @(negedge clk);
    chk("post_out", bus.out_data, model_min());
    chk("elem_cnt", {26'd0, bus.elem_cnt}, model.size());
    chk("empty", {31'd0, bus.empty}, {31'd0, model.size() == 0});
    chk("full", {31'd0, bus.full}, {31'd0, model.size() == 31});
  endtask

  initial begin
    logic [31:0] pre;
    bit e, d;
    int unsigned kind;
    logic [31:0] key;

    bus.enq      = 1'b0;
    bus.deq      = 1'b0;
    bus.inp_data = '0;

    //        enq deq data pre post cnt
    vecs[0]  = '{1'b1, 1'b0, 32'd50, 32'd0,  32'd50, 6'd1};
    vecs[1]  = '{1'b1, 1'b0, 32'd20, 32'd50, 32'd20, 6'd2};
    vecs[2]  = '{1'b1, 1'b0, 32'd70, 32'd20, 32'd20, 6'd3};
    vecs[3]  = '{1'b1, 1'b0, 32'd10, 32'd20, 32'd10, 6'd4};
    vecs[4]  = '{1'b0, 1'b1, 32'd0,  32'd10, 32'd20, 6'd3};
    vecs[5]  = '{1'b0, 1'b1, 32'd0,  32'd20, 32'd50, 6'd2};
    vecs[6]  = '{1'b0, 1'b1, 32'd0,  32'd50, 32'd70, 6'd1};
    vecs[7]  = '{1'b0, 1'b1, 32'd0,  32'd70, 32'd0,  6'd0};
    vecs[8]  = '{1'b0, 1'b1, 32'd0,  32'd0,  32'd0,  6'd0};
    vecs[9]  = '{1'b1, 1'b0, 32'd9,  32'd0,  32'd9,  6'd1};
    vecs[10] = '{1'b1, 1'b0, 32'd5,  32'd9,  32'd5,  6'd2};
    vecs[11] = '{1'b1, 1'b1, 32'd7,  32'd5,  32'd7,  6'd2};
    vecs[12] = '{1'b0, 1'b1, 32'd0,  32'd7,  32'd9,  6'd1};
    vecs[13] = '{1'b0, 1'b1, 32'd0,  32'd9,  32'd0,  6'd0};
    vecs[14] = '{1'b1, 1'b1, 32'd42, 32'd0,  32'd42, 6'd1};
    vecs[15] = '{1'b1, 1'b0, 32'd42, 32'd42, 32'd42, 6'd2};
    vecs[16] = '{1'b0, 1'b1, 32'd0,  32'd42, 32'd42, 6'd1};
    vecs[17] = '{1'b0, 1'b1, 32'd0,  32'd42, 32'd0,  6'd0};

    // Reset state
    #1;
    chk("rst_cnt", {26'd0, bus.elem_cnt}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_out", bus.out_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].e, vecs[i].d, vecs[i].x, 1'b0, pre);
      chk($sformatf("vec%0d_pre", i), pre, vecs[i].pre);
      chk($sformatf("vec%0d_post", i), bus.out_data, vecs[i].post);
      chk($sformatf("vec%0d_cnt", i), {26'd0, bus.elem_cnt}, {26'd0, vecs[i].cnt});
    end

    // Fill to capacity, overflow attempt, then drain in ascending order
    for (int i = 0; i < 31; i++) do_op(1'b1, 1'b0, $urandom, 1'b0, pre);
    chk("fill_full", {31'd0, bus.full}, 32'd1);
    do_op(1'b1, 1'b0, 32'd0, 1'b0, pre);
    chk("enq_when_full_cnt", {26'd0, bus.elem_cnt}, 32'd31);
    for (int i = 0; i < 31; i++) do_op(1'b0, 1'b1, 32'd0, 1'b0, pre);
    chk("drain_empty", {31'd0, bus.empty}, 32'd1);
    chk("drain_out", bus.out_data, 32'd0);

    // Randomized mix with back-to-back issue and stray requests while not ready
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      e    = (kind < 5) || (kind >= 8);
      d    = (kind >= 5);
      key  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      do_op(e, d, key, 1'($urandom_range(0, 1)), pre);
    end

    // Reset while an enqueue is in flight
    while (model.size() > 0) do_op(1'b0, 1'b1, 32'd0, 1'b0, pre);
    do_op(1'b1, 1'b0, 32'd30, 1'b0, pre);
    do_op(1'b1, 1'b0, 32'd10, 1'b0, pre);
    do_op(1'b1, 1'b0, 32'd20, 1'b0, pre);
    bus.enq      = 1'b1;
    bus.inp_data = 32'd5;
    @(posedge clk);
    #1;
    bus.enq = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("mid_rst_cnt", {26'd0, bus.elem_cnt}, 32'd0);
    chk("mid_rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("mid_rst_full", {31'd0, bus.full}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("mid_rst_out", bus.out_data, 32'd0);
    model.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b1, 1'b0, 32'd4, 1'b0, pre);
    chk("after_rst_out", bus.out_data, 32'd4);
    chk("after_rst_cnt", {26'd0, bus.elem_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
